// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents: opcode and funct encodings the controller decodes, ALU operation
// codes driven on alu_sec, and the controller state enum.
package mips_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Sequences the shared ALU, register file, PC and unified memory port for
// lw, sw, R-type (add/sub/and/or/slt), beq, addi and j. Counts retired
// instructions.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   opcode, funct         IR fields, stable from DECODE to the end of the instruction
//   zero                  ALU zero flag, used only in BRANCH
//   mem_ready             memory completes the current request this cycle
//   mem_req/mem_write/iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
//   alu_sec, reg_write, reg_dst, mem_to_reg   datapath controls
//   illegal_op            one-cycle pulse on unsupported opcode or funct
//   retired               completed-instruction count, wraps silently
//   dbg_state             current FSM state for observation
// Memory handshake: mem_req is raised in FETCH, MEMRD and MEMWR and stays high
// until a cycle in which mem_ready is 1; that cycle completes the transfer.
// mem_ready is ignored in every other state.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_sec,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       dbg_state
);

  state_t state;
  state_t state_nxt;
  logic   retire;

  assign dbg_state = state;

  // Outputs are decoded from the current state; only ir_write, pc_en and the
  // retire strobe additionally look at mem_ready / zero.
  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_sec    = ALU_AND;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_sec   = ALU_ADD;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // PC + (imm << 2) lands in ALUOut for a possible beq
        alu_src_b = 2'b11;
        alu_sec   = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sec   = ALU_ADD;
        state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_nxt = S_ALUWB;
        case (funct)
          FN_ADD:  alu_sec = ALU_ADD;
          FN_SUB:  alu_sec = ALU_SUB;
          FN_AND:  alu_sec = ALU_AND;
          FN_OR:   alu_sec = ALU_OR;
          FN_SLT:  alu_sec = ALU_SLT;
          default: begin
            // Unsupported funct: abandon without writeback
            alu_sec    = ALU_ADD;
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sec   = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sec   = ALU_ADD;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// Each instruction is expanded by a reference model into a per-cycle list of
// (mem_ready, zero, expected controls, retire) steps built from the
// instruction's phase sequence; the driver replays the list and compares.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode, funct;
  logic             zero, mem_ready;
  logic             mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_sec;
  logic             reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [CNT_W-1:0] retired;
  logic [3:0]       dbg_state;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sec(alu_sec),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .retired(retired), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sec;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  } ctl_t;

  ctl_t obs;
  assign obs = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                alu_src_b, alu_sec, reg_write, reg_dst, mem_to_reg, illegal_op};

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];
  logic        rdy_q[$];
  logic        zero_q[$];
  logic        ret_q[$];
  logic [5:0]  cur_op, cur_fn;
  string       cur_name;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          model_ret = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic ctl_t mk(input logic req, wr, io, irw, pce, input logic [1:0] ps,
                              input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                              input logic rw, rd, m2r, ill);
    return '{req, wr, io, irw, pce, ps, sa, sb, alu, rw, rd, m2r, ill};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
  endfunction

  // ALU code for an R-type funct; ok=0 for unsupported functs
  function automatic logic [2:0] fn_alu(input logic [5:0] f, output logic ok);
    ok = 1'b1;
    case (f)
      6'h20:   return 3'd2;
      6'h22:   return 3'd3;
      6'h24:   return 3'd0;
      6'h25:   return 3'd1;
      6'h2A:   return 3'd4;
      default: begin ok = 1'b0; return 3'd2; end
    endcase
  endfunction

  task automatic push(input ctl_t c, input logic rdy, input logic z, input logic ret);
    exp_q.push_back(c);
    rdy_q.push_back(rdy);
    zero_q.push_back(z);
    ret_q.push_back(ret);
  endtask

  // Expand one instruction into its per-cycle expectations.
  // wf / wm: cycles of mem_ready low in the fetch / data memory phase.
  task automatic expand(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int wf, input int wm);
    logic       ok;
    logic [2:0] alu;
    cur_name = name;
    cur_op   = op;
    cur_fn   = fn;
    for (int i = 0; i < wf; i++) push(mk(1,0,0,0,0,2'b00,0,2'b01,3'd2,0,0,0,0), 1'b0, rnd_bit(), 1'b0);
    push(mk(1,0,0,1,1,2'b00,0,2'b01,3'd2,0,0,0,0), 1'b1, rnd_bit(), 1'b0);
    push(mk(0,0,0,0,0,2'b00,0,2'b11,3'd2,0,0,0,!op_legal(op)), rnd_bit(), rnd_bit(), 1'b0);
    if (!op_legal(op)) return;
    case (op)
      6'h23: begin
        push(mk(0,0,0,0,0,2'b00,1,2'b10,3'd2,0,0,0,0), rnd_bit(), rnd_bit(), 1'b0);
        for (int i = 0; i < wm; i++) push(mk(1,0,1,0,0,2'b00,0,2'b00,3'd0,0,0,0,0), 1'b0, rnd_bit(), 1'b0);
        push(mk(1,0,1,0,0,2'b00,0,2'b00,3'd0,0,0,0,0), 1'b1, rnd_bit(), 1'b0);
        push(mk(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,0,1,0), rnd_bit(), rnd_bit(), 1'b1);
      end
      6'h2B: begin
        push(mk(0,0,0,0,0,2'b00,1,2'b10,3'd2,0,0,0,0), rnd_bit(), rnd_bit(), 1'b0);
        for (int i = 0; i < wm; i++) push(mk(1,1,1,0,0,2'b00,0,2'b00,3'd0,0,0,0,0), 1'b0, rnd_bit(), 1'b0);
        push(mk(1,1,1,0,0,2'b00,0,2'b00,3'd0,0,0,0,0), 1'b1, rnd_bit(), 1'b1);
      end
      6'h00: begin
        alu = fn_alu(fn, ok);
        push(mk(0,0,0,0,0,2'b00,1,2'b00,alu,0,0,0,!ok), rnd_bit(), rnd_bit(), 1'b0);
        if (ok) push(mk(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,1,0,0), rnd_bit(), rnd_bit(), 1'b1);
      end
      6'h04: push(mk(0,0,0,0,z,2'b01,1,2'b00,3'd3,0,0,0,0), rnd_bit(), z, 1'b1);
      6'h08: begin
        push(mk(0,0,0,0,0,2'b00,1,2'b10,3'd2,0,0,0,0), rnd_bit(), rnd_bit(), 1'b0);
        push(mk(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,0,0,0), rnd_bit(), rnd_bit(), 1'b1);
      end
      default: push(mk(0,0,0,0,1,2'b10,0,2'b00,3'd0,0,0,0,0), rnd_bit(), rnd_bit(), 1'b1);
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic run_steps(input int n);
    int step = 0;
    while (step < n && exp_q.size() > 0) begin
      logic [18:0] e;
      logic        r;
      e = exp_q.pop_front();
      r = ret_q.pop_front();
      @(negedge clk);
      opcode    = cur_op;
      funct     = cur_fn;
      mem_ready = rdy_q.pop_front();
      zero      = zero_q.pop_front();
      #1;
      check_eq($sformatf("%s_c%0d_ctl", cur_name, step), 32'(obs), 32'(e));
      check_eq($sformatf("%s_c%0d_retired", cur_name, step), 32'(retired), 32'(model_ret % 16));
      if (r) model_ret = (model_ret + 1) % 16;
      step++;
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    expand(name, op, fn, z, wf, wm);
    run_steps(exp_q.size());
  endtask

  // Assert reset (asynchronously), then release and check IDLE before FETCH.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    model_ret = 0;
    check_eq({name, "_rst_ctl"}, 32'(obs), 32'd0);
    check_eq({name, "_rst_retired"}, 32'(retired), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_eq({name, "_idle_ctl"}, 32'(obs), 32'd0);
    check_eq({name, "_idle_retired"}, 32'(retired), 32'd0);
    @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] op, fn;
    rst_n = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset("init");

    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3);
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
    run_instr("beq_not", 6'h04, 6'h00, 1'b0, 0, 0);
    run_instr("bad_op", 6'h3F, 6'h20, 1'b0, 0, 0);
    run_instr("bad_fn", 6'h00, 6'h07, 1'b0, 0, 0);
    run_instr("sw_wait2", 6'h2B, 6'h00, 1'b0, 2, 2);
    run_instr("addi", 6'h08, 6'h00, 1'b0, 1, 0);
    for (int i = 0; i < 17; i++) run_instr("j_wrap", 6'h02, 6'h00, 1'b0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h23;
        1: op = 6'h2B;
        2, 3: op = 6'h00;
        4: op = 6'h04;
        5: op = 6'h08;
        6: op = 6'h02;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op_legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) :
           (($urandom_range(0, 1) == 0) ? 6'h20 : 6'h2A);
      run_instr("rnd", op, fn, rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting in the load's memory-read phase
    expand("lw_abort", 6'h23, 6'h00, 1'b0, 0, 3);
    run_steps(4);
    exp_q.delete(); rdy_q.delete(); zero_q.delete(); ret_q.delete();
    do_reset("midrd");
    run_instr("post_rst_or", 6'h00, 6'h25, 1'b0, 0, 0);
    run_instr("post_rst_sub", 6'h00, 6'h22, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
